// File: rtl/sim_mem_responder.sv
// Simulation memory target: one request at a time, fixed latency, tohost mailbox halt.
// Optional macro SIM_MEM_RAND_STALL_EN adds LFSR-driven request/response stalls.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; accept latches addr/we/be/wdata
// ST_WAIT | latency down-counter running; commit when it reads 0
// ST_RESP | response presented, held until i_rsp_ready (and stall gate)

module sim_mem_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 16384,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000),
  parameter string             INIT_FILE   = ""
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_we,
  input  logic [3:0]        i_req_be,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_halt,
  output logic [31:0]       o_halt_code
);

  localparam int                IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_BYTES = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [7:0]        WAIT_INIT   = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state, next_state;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, commit;
  logic              idle_ready, rsp_go;
  logic [ADDR_W-1:0] cur_addr, offset;
  logic              cur_we;
  logic [3:0]        cur_be;
  logic [31:0]       cur_wdata;
  logic              in_range, is_tohost;
  logic [IDX_W-1:0]  idx;

`ifdef SIM_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) lfsr <= 16'hACE1;
    else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign idle_ready = lfsr[0];
  assign rsp_go     = lfsr[1];
`else
  assign idle_ready = 1'b1;
  assign rsp_go     = 1'b1;
`endif

  // With zero latency the commit happens on the accept edge, so decode the live inputs.
  always_comb begin
    cur_addr  = (state == ST_IDLE) ? i_req_addr  : lat_addr;
    cur_we    = (state == ST_IDLE) ? i_req_we    : lat_we;
    cur_be    = (state == ST_IDLE) ? i_req_be    : lat_be;
    cur_wdata = (state == ST_IDLE) ? i_req_wdata : lat_wdata;
    offset    = cur_addr - BASE_ADDR;
    in_range  = (cur_addr >= BASE_ADDR) && (offset < DEPTH_BYTES);
    idx       = offset[IDX_W+1:2];
    is_tohost = cur_we && (cur_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]);
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    commit      = 1'b0;
    o_req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        o_req_ready = idle_ready;
        if (i_req_valid && idle_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            next_state = ST_WAIT;
          end else begin
            next_state = ST_RESP;
            commit     = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 8'd0) begin
          next_state = ST_RESP;
          commit     = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready && rsp_go) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign o_rsp_valid = (state == ST_RESP);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= 8'd0;
      lat_addr    <= '0;
      lat_we      <= 1'b0;
      lat_be      <= 4'd0;
      lat_wdata   <= 32'd0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
      o_halt      <= 1'b0;
      o_halt_code <= 32'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_addr  <= i_req_addr;
        lat_we    <= i_req_we;
        lat_be    <= i_req_be;
        lat_wdata <= i_req_wdata;
        wait_cnt  <= WAIT_INIT;
      end else if (state == ST_WAIT && wait_cnt != 8'd0) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if (commit) begin
        o_rsp_rdata <= (cur_we || !in_range) ? 32'd0 : mem[idx];
        o_rsp_err   <= !in_range && !is_tohost;
        if (is_tohost && !o_halt) begin
          o_halt      <= 1'b1;
          o_halt_code <= cur_wdata;
        end
      end
    end
  end

  // Backing store is never reset; a write in flight when reset hits is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && commit && cur_we && in_range && !is_tohost) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sim_mem_responder.sv
// Randomized bench for sim_mem_responder against a transaction-level memory model,
// plus directed latency/byte-enable/range/tohost/reset scenarios with literal expectations.

module tb_sim_mem_responder;

  localparam int          DEPTH  = 64;
  localparam int          WAIT   = 3;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_we, i_rsp_ready;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [3:0]  i_req_be;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_halt;
  logic [31:0] o_rsp_rdata, o_halt_code;

  int errors = 0;
  int checks = 0;

  sim_mem_responder #(
    .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
    .WAIT_CYCLES(WAIT), .TOHOST_ADDR(TOHOST), .INIT_FILE("")
  ) u_dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_we(i_req_we), .i_req_be(i_req_be),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_halt(o_halt), .o_halt_code(o_halt_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: response due WAIT+1 cycles after accept, memory effect applied then.
  logic [31:0] mdl_mem [DEPTH];
  bit          busy = 0, pend = 0, m_halt = 0;
  logic [31:0] m_code = 0;
  int          cyc = 0, acc_cyc = 0;
  bit          p_we, p_inr, p_th;
  int          p_idx;
  logic [3:0]  p_be;
  logic [31:0] p_wdata, e_rdata;
  bit          e_err;

  always @(negedge clk) begin
    bit      due;
    longint  la;
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
      chk("rst_halt", 32'(o_halt), 32'd0);
      chk("rst_halt_code", o_halt_code, 32'd0);
      busy = 0; pend = 0; m_halt = 0; m_code = 0;
    end else begin
      due = busy && (cyc - acc_cyc >= WAIT + 1);
      if (due && pend) begin
        pend = 0;
        if (p_we && p_th) begin
          if (!m_halt) begin m_halt = 1; m_code = p_wdata; end
        end else if (p_we && p_inr) begin
          for (int b = 0; b < 4; b++)
            if (p_be[b]) mdl_mem[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
        end
      end
      chk("req_ready", 32'(o_req_ready), 32'(!busy));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(due));
      if (due) begin
        chk("rsp_rdata", o_rsp_rdata, e_rdata);
        chk("rsp_err", 32'(o_rsp_err), 32'(e_err));
      end
      chk("halt", 32'(o_halt), 32'(m_halt));
      chk("halt_code", o_halt_code, m_code);
      if (due && i_rsp_ready) begin
        busy = 0;
      end else if (!busy && i_req_valid) begin
        la      = longint'(i_req_addr);
        p_inr   = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
        p_idx   = p_inr ? int'((la - longint'(BASE)) / 4) : 0;
        p_th    = i_req_we && ((i_req_addr & ~32'h3) == TOHOST);
        p_we    = i_req_we;
        p_be    = i_req_be;
        p_wdata = i_req_wdata;
        e_err   = !p_inr && !p_th;
        e_rdata = (i_req_we || !p_inr) ? 32'd0 : mdl_mem[p_idx];
        busy    = 1;
        pend    = 1;
        acc_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic junk();
    i_req_valid = 1'($urandom_range(0, 1));
    i_req_addr  = $urandom;
    i_req_we    = 1'($urandom_range(0, 1));
    i_req_be    = 4'($urandom);
    i_req_wdata = $urandom;
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err);
    int  n;
    bit  ok;
    rdata = 32'hx; err = 1'bx;
    @(posedge clk); #1;
    i_req_valid = 1; i_req_we = we; i_req_addr = addr; i_req_be = be; i_req_wdata = wdata;
    i_rsp_ready = 0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_req_ready) begin ok = 1; break; end
    end
    if (!ok) begin chk("accept_timeout", 32'd0, 32'd1); i_req_valid = 0; return; end
    ok = 0;
    for (n = 1; n <= 300; n++) begin
      @(posedge clk); #1; junk();
      @(negedge clk);
      if (o_rsp_valid) begin ok = 1; break; end
    end
    if (!ok) begin chk("rsp_timeout", 32'd0, 32'd1); i_req_valid = 0; return; end
    chk("latency", 32'(n), 32'(WAIT + 1));
    rdata = o_rsp_rdata; err = o_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1; junk();
    end
    @(posedge clk); #1; junk(); i_rsp_ready = 1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_rsp_ready = 0; i_req_valid = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          k;
    rst_n = 0; i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_be = 0;
    i_req_wdata = 0; i_rsp_ready = 0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i <= 8; i++) txn(1, BASE + 32'(4 * i), 4'hF, $urandom, 0, rd, er);
    txn(1, BASE + 32'(4 * (DEPTH - 1)), 4'hF, 32'h0BAD_F00D, 0, rd, er);

    // word 0 fetch
    txn(1, BASE, 4'hF, 32'h0000_0013, 0, rd, er);
    txn(0, BASE, 4'h0, 32'd0, 0, rd, er);
    chk("t1_rdata", rd, 32'h0000_0013);
    chk("t1_err", 32'(er), 32'd0);

    // partial byte-enable write
    txn(1, BASE + 32'h10, 4'hF, 32'h1122_3344, 0, rd, er);
    txn(1, BASE + 32'h10, 4'b0011, 32'hAABB_CCDD, 0, rd, er);
    chk("t2_wr_rdata", rd, 32'd0);
    txn(0, BASE + 32'h12, 4'h0, 32'd0, 5, rd, er);
    chk("t2_rdata", rd, 32'h1122_CCDD);
    @(negedge clk);
    chk("t3_ready_after", 32'(o_req_ready), 32'd1);

    // range boundaries
    txn(0, BASE + 32'(4 * DEPTH), 4'h0, 32'd0, 0, rd, er);
    chk("t4_err", 32'(er), 32'd1);
    chk("t4_rdata", rd, 32'd0);
    txn(1, BASE + 32'(4 * DEPTH), 4'hF, 32'hFFFF_FFFF, 0, rd, er);
    chk("t4_wr_err", 32'(er), 32'd1);
    txn(0, BASE + 32'(4 * (DEPTH - 1)), 4'h0, 32'd0, 0, rd, er);
    chk("t4_last", rd, 32'h0BAD_F00D);
    chk("t4_last_err", 32'(er), 32'd0);
    txn(0, BASE - 32'd4, 4'h0, 32'd0, 0, rd, er);
    chk("t4_below_err", 32'(er), 32'd1);

    // tohost mailbox
    txn(1, TOHOST, 4'hF, 32'h1, 0, rd, er);
    chk("t5_err1", 32'(er), 32'd0);
    txn(1, TOHOST + 32'd2, 4'hF, 32'h3, 0, rd, er);
    chk("t5_err2", 32'(er), 32'd0);
    @(negedge clk);
    chk("t5_halt", 32'(o_halt), 32'd1);
    chk("t5_code", o_halt_code, 32'h1);

    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 12);
      if (k <= 8)       a = BASE + 32'(4 * k);
      else if (k == 9)  a = BASE + 32'(4 * (DEPTH - 1));
      else if (k == 10) a = BASE + 32'(4 * DEPTH);
      else if (k == 11) a = BASE - 32'd4;
      else              a = TOHOST;
      a = a | 32'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, $urandom_range(0, 3), rd, er);
    end
    @(negedge clk);
    chk("halt_sticky", o_halt_code, 32'h1);

    // reset while a write is waiting
    txn(1, BASE + 32'h20, 4'hF, 32'd0, 0, rd, er);
    @(posedge clk); #1;
    i_req_valid = 1; i_req_we = 1; i_req_addr = BASE + 32'h20; i_req_be = 4'hF;
    i_req_wdata = 32'hDEAD_BEEF;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (o_req_ready) break;
    end
    @(posedge clk); #1; i_req_valid = 0;
    @(negedge clk);
    @(posedge clk); #1; rst_n = 0;
    #1;
    chk("t6_valid_async", 32'(o_rsp_valid), 32'd0);
    chk("t6_halt_async", 32'(o_halt), 32'd0);
    chk("t6_code_async", o_halt_code, 32'd0);
    @(posedge clk); #1; rst_n = 1;
    txn(0, BASE + 32'h20, 4'h0, 32'd0, 0, rd, er);
    chk("t6_readback", rd, 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
